// File: rtl/aging_pkg.sv
// Shared types and helpers for the aging/sysmon UART frame transmitter.
package aging_pkg;

  localparam logic [7:0] AGING_SYNC_BYTE = 8'hA5;

  typedef struct packed {
    logic       alarm;
    logic [2:0] rsvd;
    logic [3:0] seq;
  } aging_hdr_t;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    BYTE,
    GUARD
  } aging_tx_state_e;

  // One byte of CRC-8 (poly 0x07, MSB first, no reflection)
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, DIV cycles per bit.
// ready_o is also high in the final cycle of the stop bit so bytes can run back to back.
module uart_tx_byte #(
  parameter int unsigned DIV = 173
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] byte_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam logic [15:0] DIV_M1 = 16'(DIV - 1);

  logic        busy_q, busy_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        last_tick;

  assign last_tick = busy_q && (baud_q == DIV_M1) && (bit_q == 4'd9);
  assign ready_o   = !busy_q || last_tick;
  assign tx_o      = tx_q;

  // Bit timing and shift: load on handshake, advance one bit every DIV cycles
  always_comb begin
    busy_d = busy_q;
    baud_d = baud_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    tx_d   = tx_q;
    if (ready_o && valid_i) begin
      busy_d = 1'b1;
      baud_d = '0;
      bit_d  = '0;
      sh_d   = {1'b1, byte_i};
      tx_d   = 1'b0;
    end else if (busy_q) begin
      if (baud_q == DIV_M1) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          tx_d   = 1'b1;
        end else begin
          tx_d  = sh_q[0];
          sh_d  = {1'b1, sh_q[8:1]};
          bit_d = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + 16'd1;
      end
    end
  end

  // Serialiser state registers; line idles high in reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= 1'b0;
      baud_q <= '0;
      bit_q  <= '0;
      sh_q   <= '1;
      tx_q   <= 1'b1;
    end else begin
      busy_q <= busy_d;
      baud_q <= baud_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      tx_q   <= tx_d;
    end
  end

endmodule

// File: rtl/aging_frame_tx.sv
// Frames one aging/sysmon sample (SYNC, HDR, payload LSB byte first, CHK) and sends it 8N1.
// tx_active_o covers the lead-in bit, all bytes and the guard time.
// Build option AGING_FRAME_CRC_EN: CHK is CRC-8/0x07 instead of the XOR checksum.
module aging_frame_tx
  import aging_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 20000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned PAYLOAD_BYTES = 4,
  parameter int unsigned GUARD_BITS    = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       sample_valid_i,
  output logic                       sample_ready_o,
  input  logic [8*PAYLOAD_BYTES-1:0] sample_data_i,
  input  logic                       alarm_i,
  output logic                       tx_o,
  output logic                       tx_active_o
);

  localparam int unsigned DIV      = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] DIV_M1   = 16'(DIV - 1);
  localparam logic [3:0]  LAST_IDX = 4'(PAYLOAD_BYTES + 2);
  localparam logic [3:0]  END_IDX  = 4'(PAYLOAD_BYTES + 3);
  localparam logic [7:0]  GUARD_M1 = 8'(GUARD_BITS - 1);

  aging_tx_state_e            state_q, state_d;
  logic [8*PAYLOAD_BYTES-1:0] data_q, data_d;
  logic                       alarm_q, alarm_d;
  logic [3:0]                 seq_q, seq_d;
  logic [15:0]                baud_q, baud_d;
  logic [7:0]                 gbit_q, gbit_d;
  logic [3:0]                 idx_q, idx_d;
  logic [7:0]                 chk_q, chk_d;
  logic                       ready_q, ready_d;
  logic                       active_q, active_d;

  aging_hdr_t hdr;
  logic [7:0] byte_data;
  logic [7:0] chk_next;
  logic       byte_valid;
  logic       byte_ready;

  assign sample_ready_o = ready_q;
  assign tx_active_o    = active_q;

  // Byte currently offered to the serialiser, selected by slot index
  always_comb begin
    hdr       = '{alarm: alarm_q, rsvd: 3'b000, seq: seq_q};
    byte_data = chk_q;
    if (idx_q == 4'd0) begin
      byte_data = AGING_SYNC_BYTE;
    end else if (idx_q == 4'd1) begin
      byte_data = hdr;
    end else begin
      for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
        if (idx_q == 4'(i + 2)) byte_data = data_q[8*i +: 8];
      end
    end
`ifdef AGING_FRAME_CRC_EN
    chk_next = crc8_step(chk_q, byte_data);
`else
    chk_next = chk_q ^ byte_data;
`endif
  end

  // Frame sequencer: lead-in bit, byte slots, guard time, back to idle
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    alarm_d    = alarm_q;
    seq_d      = seq_q;
    baud_d     = baud_q;
    gbit_d     = gbit_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    ready_d    = ready_q;
    active_d   = active_q;
    byte_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (sample_valid_i && ready_q) begin
          data_d   = sample_data_i;
          alarm_d  = alarm_i;
          state_d  = LEAD;
          baud_d   = '0;
          idx_d    = '0;
          chk_d    = '0;
          ready_d  = 1'b0;
          active_d = 1'b1;
        end
      end
      LEAD: begin
        if (baud_q == DIV_M1) begin
          byte_valid = 1'b1;
          if (byte_ready) begin
            idx_d   = 4'd1;
            state_d = BYTE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      BYTE: begin
        if (idx_q != END_IDX) begin
          byte_valid = 1'b1;
          if (byte_ready) begin
            idx_d = idx_q + 4'd1;
            // HDR and payload slots feed the checksum, which is complete before CHK is sent
            if (idx_q != LAST_IDX) chk_d = chk_next;
          end
        end else if (byte_ready) begin
          state_d = GUARD;
          baud_d  = '0;
          gbit_d  = '0;
        end
      end
      GUARD: begin
        if (baud_q == DIV_M1) begin
          baud_d = '0;
          if (gbit_q == GUARD_M1) begin
            state_d  = IDLE;
            active_d = 1'b0;
            ready_d  = 1'b1;
            seq_d    = seq_q + 4'd1;
          end else begin
            gbit_d = gbit_q + 8'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      data_q   <= '0;
      alarm_q  <= 1'b0;
      seq_q    <= '0;
      baud_q   <= '0;
      gbit_q   <= '0;
      idx_q    <= '0;
      chk_q    <= '0;
      ready_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      alarm_q  <= alarm_d;
      seq_q    <= seq_d;
      baud_q   <= baud_d;
      gbit_q   <= gbit_d;
      idx_q    <= idx_d;
      chk_q    <= chk_d;
      ready_q  <= ready_d;
      active_q <= active_d;
    end
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_byte (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .byte_i (byte_data),
    .valid_i(byte_valid),
    .ready_o(byte_ready),
    .tx_o   (tx_o)
  );

endmodule

// File: tb/tb_aging_frame_tx.sv
// Bench for aging_frame_tx: line-level frame model plus table and hand-written sequences.
// Uses a reduced clock so that DIV = 1600000/115200 = 13 (truncated) keeps runs short.
module tb_aging_frame_tx;

  localparam int CLK_FREQ  = 1600000;
  localparam int BAUD_RATE = 115200;
  localparam int PB        = 4;
  localparam int GB        = 2;
  localparam int DIV       = CLK_FREQ / BAUD_RATE;
  localparam int NB        = PB + 3;
  localparam int NBITS     = 1 + 10 * NB + GB;
  localparam int FLEN      = NBITS * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic          sample_ready_o;
  logic [8*PB-1:0] sample_data = '0;
  logic          alarm = 1'b0;
  logic          tx_o;
  logic          tx_active_o;

  aging_frame_tx #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD_RATE(BAUD_RATE),
    .PAYLOAD_BYTES(PB),
    .GUARD_BITS(GB)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .sample_valid_i(sample_valid),
    .sample_ready_o(sample_ready_o),
    .sample_data_i(sample_data),
    .alarm_i(alarm),
    .tx_o(tx_o),
    .tx_active_o(tx_active_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference checksum over HDR + payload
  function automatic logic [7:0] chk_of(input logic [7:0] hdr, input logic [8*PB-1:0] d);
`ifdef AGING_FRAME_CRC_EN
    // Remainder of (message * x^8) divided by x^8 + x^2 + x + 1
    logic [7:0] msg [PB+2];
    logic [8:0] rem;
    logic       bv;
    msg[0] = hdr;
    for (int j = 0; j < PB; j++) msg[j+1] = d[8*j +: 8];
    msg[PB+1] = 8'h00;
    rem = '0;
    for (int j = 0; j < PB + 2; j++) begin
      for (int b = 7; b >= 0; b--) begin
        bv  = msg[j][b];
        rem = {rem[7:0], bv};
        if (rem[8]) rem = rem ^ 9'h107;
      end
    end
    return rem[7:0];
`else
    logic [7:0] x;
    x = hdr;
    for (int j = 0; j < PB; j++) x = x ^ d[8*j +: 8];
    return x;
`endif
  endfunction

  // ---------------- line model / decoder ----------------
  logic [7:0] exp_b [NB];
  logic [7:0] rx_b  [NB];
  logic       rx_line [NBITS];
  logic [3:0] m_seq = '0;
  int         m_pos = -1;
  int         wave_err = 0;
  int         idle_err = 0;
  int         frames_done = 0;
  int         b2b_cnt = 0;
  bit         post_idle = 1'b0;
  int         act_run = 0;
  int         last_act_len = 0;

  function automatic logic line_bit(input int b);
    int j;
    int p;
    if (b == 0 || b > 10 * NB) return 1'b1;
    j = (b - 1) / 10;
    p = (b - 1) % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return exp_b[j][p-1];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_pos     = -1;
      m_seq     = '0;
      post_idle = 1'b0;
    end else if (m_pos >= 0) begin
      if (tx_o !== line_bit(m_pos / DIV) || tx_active_o !== 1'b1 || sample_ready_o !== 1'b0)
        wave_err++;
      if (m_pos % DIV == DIV / 2) rx_line[m_pos / DIV] = tx_o;
      m_pos++;
      if (m_pos == FLEN) begin
        check("frame waveform errors", 64'(wave_err), 64'd0);
        for (int j = 0; j < NB; j++) begin
          for (int i = 0; i < 8; i++) rx_b[j][i] = rx_line[2 + 10*j + i];
          check($sformatf("frame byte %0d", j), 64'(rx_b[j]), 64'(exp_b[j]));
        end
        m_seq     = m_seq + 4'd1;
        frames_done++;
        m_pos     = -1;
        post_idle = 1'b1;
      end
    end else begin
      if (post_idle) begin
        check("guard->idle active/ready", {62'd0, tx_active_o, sample_ready_o}, 64'b01);
        if (sample_ready_o && sample_valid) b2b_cnt++;
        post_idle = 1'b0;
      end else if (tx_o !== 1'b1 || tx_active_o !== 1'b0) begin
        idle_err++;
      end
      if (sample_ready_o === 1'b1 && sample_valid) begin
        exp_b[0] = 8'hA5;
        exp_b[1] = {alarm, 3'b000, m_seq};
        for (int j = 0; j < PB; j++) exp_b[2+j] = sample_data[8*j +: 8];
        exp_b[NB-1] = chk_of(exp_b[1], sample_data);
        m_pos    = 0;
        wave_err = 0;
      end
    end
  end

  // Length of each tx_active_o pulse
  always @(negedge clk) begin
    if (!rst_n) act_run = 0;
    else if (tx_active_o) act_run++;
    else if (act_run != 0) begin
      last_act_len = act_run;
      act_run      = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [8*PB-1:0] d, input logic a);
    int n = 0;
    @(posedge clk); #1;
    while (sample_ready_o !== 1'b1 && n < 3 * FLEN) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready before send", 64'(sample_ready_o), 64'd1);
    sample_valid = 1'b1;
    sample_data  = d;
    alarm        = a;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    sample_data  = $urandom;
    alarm        = 1'($urandom);
  endtask

  task automatic wait_frame(input int start);
    int n = 0;
    while (frames_done == start && n < 3 * FLEN) begin
      @(negedge clk);
      n++;
    end
    check("frame completed in time", 64'(frames_done != start), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [8*PB-1:0] data;
    logic            alarm;
    logic [7:0]      hdr;
    logic [7:0]      chk;
  } vec_t;

  vec_t vt [4];

  initial begin
    int start;
    int b0;
    int n;
    logic [7:0] h;

    vt[0] = '{data: 32'h12345678, alarm: 1'b0, hdr: 8'h00, chk: 8'h08};
    vt[1] = '{data: 32'h000000FF, alarm: 1'b1, hdr: 8'h81, chk: 8'h7E};
    vt[2] = '{data: 32'hA5A50000, alarm: 1'b1, hdr: 8'h82, chk: 8'h82};
    vt[3] = '{data: 32'hFFFFFFFF, alarm: 1'b0, hdr: 8'h03, chk: 8'h03};
`ifdef AGING_FRAME_CRC_EN
    for (int i = 0; i < 4; i++) vt[i].chk = chk_of(vt[i].hdr, vt[i].data);
`endif

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset tx_o", 64'(tx_o), 64'd1);
    check("reset tx_active_o", 64'(tx_active_o), 64'd0);
    check("reset sample_ready_o", 64'(sample_ready_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready after reset release", 64'(sample_ready_o), 64'd1);

    // Table of spec frames: header, checksum, payload and active length
    for (int i = 0; i < 4; i++) begin
      start = frames_done;
      send(vt[i].data, vt[i].alarm);
      wait_frame(start);
      check($sformatf("vec%0d hdr", i), 64'(rx_b[1]), 64'(vt[i].hdr));
      check($sformatf("vec%0d chk", i), 64'(rx_b[NB-1]), 64'(vt[i].chk));
      for (int j = 0; j < PB; j++)
        check($sformatf("vec%0d payload %0d", i, j), 64'(rx_b[2+j]), 64'(vt[i].data[8*j +: 8]));
      check($sformatf("vec%0d active length", i), 64'(last_act_len), 64'(FLEN));
    end

    // valid held high with data changing every cycle: accept lands on the first IDLE cycle
    start = frames_done;
    b0    = b2b_cnt;
    n     = 0;
    @(posedge clk); #1;
    sample_valid = 1'b1;
    while (frames_done < start + 3 && n < 5 * FLEN) begin
      sample_data = $urandom;
      alarm       = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    sample_valid = 1'b0;
    check("held-valid frames completed", 64'(frames_done - start), 64'd3);
    check("held-valid immediate re-accepts", 64'(b2b_cnt - b0), 64'd2);
    repeat (3) @(negedge clk);

    // 17 frames after reset: seq 0..15 then wraps to 0
    do_reset();
    for (int i = 0; i < 17; i++) begin
      start = frames_done;
      send($urandom, 1'($urandom));
      wait_frame(start);
      h = {rx_b[1][7], 3'b000, 4'(i % 16)};
      check($sformatf("seq frame %0d hdr", i), 64'(rx_b[1]), 64'(h));
    end

    // Async reset mid-payload (byte 3, bit 4); aborted frame does not advance seq
    send(32'h12345678, 1'b0);
    repeat (DIV * (1 + 30 + 4) + DIV / 2) @(posedge clk);
    #3;
    check("pre-abort tx_active_o", 64'(tx_active_o), 64'd1);
    check("pre-abort tx_o (data bit 0)", 64'(tx_o), 64'd0);
    rst_n = 1'b0;
    #1;
    check("async reset tx_o", 64'(tx_o), 64'd1);
    check("async reset tx_active_o", 64'(tx_active_o), 64'd0);
    check("async reset sample_ready_o", 64'(sample_ready_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready after abort", 64'(sample_ready_o), 64'd1);
    start = frames_done;
    send(32'hCAFE0001, 1'b1);
    wait_frame(start);
    check("hdr after abort", 64'(rx_b[1]), 64'h80);

    check("idle line errors", 64'(idle_err), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
